// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU/memory-side types.
//     word_t      : 32-bit machine word
//     ramstate_t  : status reported by the variable-latency RAM
//     arb_state_t : memory_arbiter FSM states
//     arb_owner_t : which requester currently owns the RAM port
//     arb_op_t    : latched RAM operation for the granted request
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Serialises instruction-fetch and data load/store requests onto the single
//   port of a variable-latency RAM. One request is in flight at a time; each
//   completes with a registered one-cycle DONE state in which the owner's wait
//   drops. Ties alternate between the two sides, a watchdog force-completes a
//   request the RAM never acknowledges, and a sticky fault flag records
//   timeouts and RAM errors.
//
// Parameters
//   TIMEOUT : cycles in GRANT without ACCESS before force-completion
//   BAD     : load value returned on a faulted completion
//
// Ports
//   CLK, RST           : clock (rising edge), synchronous active-high reset
//   iREN, iaddr        : instruction read request / word address
//   iwait, iload       : instruction stall / returned data
//   dREN, dWEN         : data read / write request (write wins if both)
//   daddr, dstore      : data address / store data
//   dwait, dload       : data stall / returned read data
//   ramREN, ramWEN     : RAM request strobes (never both high)
//   ramaddr, ramstore  : RAM address / write data
//   ramload, ramstate  : RAM read data / RAM status
//   fault              : sticky timeout-or-error flag
// -----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT = 64,
    parameter word_t BAD     = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      RST,

    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,

    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,

    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,

    output logic      fault
);

    localparam int             TCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);

    arb_state_t     state_q,      state_d;
    arb_owner_t     owner_q,      owner_d;
    arb_owner_t     last_owner_q, last_owner_d;
    arb_op_t        op_q,         op_d;
    word_t          addr_q,       addr_d;
    word_t          store_q,      store_d;
    word_t          rdata_q,      rdata_d;
    logic [TCW-1:0] tcount_q,     tcount_d;
    logic           fault_q,      fault_d;

    logic       i_req;
    logic       d_req;
    logic       owner_req;
    arb_owner_t grant_sel;

    assign i_req     = iREN;
    assign d_req     = dREN | dWEN;
    assign owner_req = (owner_q == OWN_D) ? d_req : i_req;

    // On a tie the side that did not complete last wins, so two held
    // requesters alternate strictly.
    always_comb begin
        grant_sel = OWN_I;
        if (i_req && d_req) begin
            grant_sel = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant_sel = OWN_D;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        store_d      = store_q;
        rdata_d      = rdata_q;
        tcount_d     = tcount_q;
        fault_d      = fault_q;

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    owner_d  = grant_sel;
                    tcount_d = '0;
                    state_d  = ARB_GRANT;
                    if (grant_sel == OWN_D) begin
                        op_d    = dWEN ? OP_WRITE : OP_READ;
                        addr_d  = daddr;
                        store_d = dstore;
                    end else begin
                        op_d    = OP_READ;
                        addr_d  = iaddr;
                        store_d = '0;
                    end
                end
            end

            ARB_GRANT: begin
                // A withdrawn request is dropped silently; no completion and
                // the fairness history is left untouched.
                if (!owner_req) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    rdata_d = ramload;
                    state_d = ARB_DONE;
                end else if (ramstate == ERROR || tcount_q == TC_LAST) begin
                    fault_d = 1'b1;
                    rdata_d = BAD;
                    state_d = ARB_DONE;
                end else begin
                    tcount_d = tcount_q + TCW'(1);
                end
            end

            ARB_DONE: begin
                last_owner_d = owner_q;
                state_d      = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            rdata_q      <= '0;
            tcount_q     <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rdata_q      <= rdata_d;
            tcount_q     <= tcount_d;
            fault_q      <= fault_d;
        end
    end

    // Request fields are only consumed in GRANT, which is always entered
    // through IDLE where they are loaded, so they need no reset.
    always_ff @(posedge CLK) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        store_q <= store_d;
    end

    // RAM is driven only from latched fields in GRANT; strobes drop in DONE
    // and IDLE so the RAM restarts its latency count for every request.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == ARB_GRANT) begin
            ramREN   = (op_q == OP_READ);
            ramWEN   = (op_q == OP_WRITE);
            ramaddr  = addr_q;
            ramstore = store_q;
        end
    end

    assign iwait = iREN & ~((state_q == ARB_DONE) && (owner_q == OWN_I));
    assign dwait = d_req & ~((state_q == ARB_DONE) && (owner_q == OWN_D));
    assign iload = rdata_q;
    assign dload = rdata_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int    TO  = 8;
    localparam word_t BADV = 32'hBAD1BAD1;

    logic      CLK, RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      fault;

    memory_arbiter #(.TIMEOUT(TO), .BAD(BADV)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .fault(fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- RAM model: ACCESS on the 4th strobed cycle ----------
    int ram_mode = 0;   // 0 normal, 1 never answers, 2 error
    int rcnt     = 0;
    int cur_row  = -1;
    int both_hi  = 0;
    word_t wr_addr[$];
    word_t wr_data[$];
    int    wr_row[$];

    function automatic word_t rom(input word_t a);
        case (a)
            32'h40:  return 32'h8C220004;
            32'h80:  return 32'h24420001;
            32'h200: return 32'hAABBCCDD;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (ramREN || ramWEN) rcnt <= rcnt + 1;
        else                  rcnt <= 0;
        if (ramWEN && ramstate == ACCESS) begin
            wr_addr.push_back(ramaddr);
            wr_data.push_back(ramstore);
            wr_row.push_back(cur_row);
        end
    end

    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN) begin
            if (ram_mode == 1)      ramstate = BUSY;
            else if (ram_mode == 2) ramstate = ERROR;
            else if (rcnt == 3)     ramstate = ACCESS;
            else                    ramstate = BUSY;
        end
    end

    assign ramload = rom(ramaddr);

    always @(negedge CLK) begin
        if (ramREN && ramWEN) both_hi <= both_hi + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic  rst, ir, dr, dw;
        word_t ia, da, ds;
        logic  e_iwait, e_dwait, e_ren, e_wen;
        word_t e_addr, e_store;
        int    ld;      // 0 no load check, 1 iload, 2 dload
        word_t e_ld;
        logic  e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ir, logic dr, logic dw,
                                word_t ia, word_t da, word_t ds,
                                logic ewi, logic ewd, logic er, logic ew,
                                word_t ea, word_t es, int ld, word_t eld, logic ef);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw;
        v.ia = ia; v.da = da; v.ds = ds;
        v.e_iwait = ewi; v.e_dwait = ewd; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_store = es; v.ld = ld; v.e_ld = eld; v.e_fault = ef;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;

        // reset behaviour (rows 0-2)
        vecs.push_back(mk(1,1,0,0, 0,0,0, 1,0,0,0, 0,0, 1,0, 0));
        vecs.push_back(mk(1,0,0,1, 0,0,0, 0,1,0,0, 0,0, 2,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 2,0, 0));
        // single instruction read, 0x40 (rows 3-9)
        vecs.push_back(mk(0,1,0,0, 32'h40,0,0, 1,0,0,0, 0,0, 0,0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,0, 32'h40,0,0, 1,0,1,0, 32'h40,0, 0,0, 0));
        vecs.push_back(mk(0,1,0,0, 32'h40,0,0, 0,0,0,0, 0,0, 1,32'h8C220004, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,32'h8C220004, 0));
        // tie: data write vs instruction read (rows 10-22)
        vecs.push_back(mk(0,1,0,1, 32'h80,32'h100,32'hDEADBEEF, 1,1,0,0, 0,0, 0,0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,1, 32'h80,32'h100,32'hDEADBEEF, 1,1,0,1, 32'h100,32'hDEADBEEF, 0,0, 0));
        vecs.push_back(mk(0,1,0,1, 32'h80,32'h100,32'hDEADBEEF, 1,0,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,1,0,0, 32'h80,0,0, 1,0,0,0, 0,0, 0,0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,0,0, 32'h80,0,0, 1,0,1,0, 32'h80,0, 0,0, 0));
        vecs.push_back(mk(0,1,0,0, 32'h80,0,0, 0,0,0,0, 0,0, 1,32'h24420001, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 1,32'h24420001, 0));
        // dREN+dWEN together decodes as write (rows 23-29)
        vecs.push_back(mk(0,0,1,1, 0,32'h200,32'h11223344, 0,1,0,0, 0,0, 0,0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,0,1,1, 0,32'h200,32'h11223344, 0,1,0,1, 32'h200,32'h11223344, 0,0, 0));
        vecs.push_back(mk(0,0,1,1, 0,32'h200,32'h11223344, 0,0,0,0, 0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0, 0));
        // data read of 0x200 (rows 30-36)
        vecs.push_back(mk(0,0,1,0, 0,32'h200,0, 0,1,0,0, 0,0, 0,0, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,0,1,0, 0,32'h200,0, 0,1,1,0, 32'h200,0, 0,0, 0));
        vecs.push_back(mk(0,0,1,0, 0,32'h200,0, 0,0,0,0, 0,0, 2,32'hAABBCCDD, 0));
        vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 2,32'hAABBCCDD, 0));

        repeat (2) @(posedge CLK);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            cur_row = k;
            RST = vecs[k].rst; iREN = vecs[k].ir; dREN = vecs[k].dr; dWEN = vecs[k].dw;
            iaddr = vecs[k].ia; daddr = vecs[k].da; dstore = vecs[k].ds;
            @(negedge CLK);
            chk($sformatf("row%0d iwait", k),  iwait,  vecs[k].e_iwait);
            chk($sformatf("row%0d dwait", k),  dwait,  vecs[k].e_dwait);
            chk($sformatf("row%0d ramREN", k), ramREN, vecs[k].e_ren);
            chk($sformatf("row%0d ramWEN", k), ramWEN, vecs[k].e_wen);
            chk($sformatf("row%0d ramaddr", k), ramaddr, vecs[k].e_addr);
            chk($sformatf("row%0d ramstore", k), ramstore, vecs[k].e_store);
            chk($sformatf("row%0d fault", k),  fault,  vecs[k].e_fault);
            if (vecs[k].ld == 1) chk($sformatf("row%0d iload", k), iload, vecs[k].e_ld);
            if (vecs[k].ld == 2) chk($sformatf("row%0d dload", k), dload, vecs[k].e_ld);
            step();
        end
        cur_row = -1;

        chk("write_count", wr_row.size(), 2);
        if (wr_row.size() == 2) begin
            chk("write0_row",  wr_row[0],  14);
            chk("write0_addr", wr_addr[0], 32'h100);
            chk("write0_data", wr_data[0], 32'hDEADBEEF);
            chk("write1_row",  wr_row[1],  27);
            chk("write1_addr", wr_addr[1], 32'h200);
            chk("write1_data", wr_data[1], 32'h11223344);
        end

        // ---------- fairness: both held, 6 completions ----------
        RST = 1'b1; step(); RST = 1'b0;
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h200; dWEN = 0; dstore = 0;
        begin
            int ncomp;
            int last_c;
            ncomp = 0; last_c = -1;
            for (int c = 0; c < 60 && ncomp < 6; c++) begin
                @(negedge CLK);
                if (!iwait || !dwait) begin
                    chk($sformatf("fair_owner%0d", ncomp), !dwait ? 32'd68 : 32'd73,
                        (ncomp % 2 == 0) ? 32'd68 : 32'd73);
                    chk($sformatf("fair_gap%0d", ncomp), c - last_c, 6);
                    chk($sformatf("fair_load%0d", ncomp), iload,
                        (ncomp % 2 == 0) ? 32'hAABBCCDD : 32'h8C220004);
                    last_c = c;
                    ncomp++;
                end
                step();
            end
            chk("fair_completions", ncomp, 6);
        end
        iREN = 0; dREN = 0;
        step();

        // ---------- timeout ----------
        ram_mode = 1;
        dREN = 1; daddr = 32'h300;
        for (int c = 0; c <= 9; c++) begin
            @(negedge CLK);
            chk($sformatf("to_dwait_c%0d", c), dwait, (c == 9) ? 1'b0 : 1'b1);
            if (c == 8) chk("to_fault_before", fault, 0);
            if (c == 9) begin
                chk("to_dload", dload, BADV);
                chk("to_fault", fault, 1);
            end
            step();
        end
        dREN = 0;
        ram_mode = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("to_fault_sticky%0d", c), fault, 1);
            step();
        end

        // ---------- RAM ERROR ----------
        ram_mode = 2;
        iREN = 1; iaddr = 32'h40;
        for (int c = 0; c <= 2; c++) begin
            @(negedge CLK);
            chk($sformatf("err_iwait_c%0d", c), iwait, (c == 2) ? 1'b0 : 1'b1);
            if (c == 2) chk("err_iload", iload, BADV);
            step();
        end
        iREN = 0;
        ram_mode = 0;
        step();

        // ---------- abort of a data request ----------
        dREN = 1; daddr = 32'h200;
        @(negedge CLK); chk("abort_c0_ren", ramREN, 0); step();
        @(negedge CLK); chk("abort_c1_ren", ramREN, 1); step();
        dREN = 0;
        @(negedge CLK);
        chk("abort_c2_ren", ramREN, 1);
        chk("abort_c2_dwait", dwait, 0);
        step();
        @(negedge CLK);
        chk("abort_c3_ren", ramREN, 0);
        chk("abort_c3_dload", dload, BADV);
        step();

        // tie after abort: data must still win (history unchanged)
        dREN = 1; daddr = 32'h200; iREN = 1; iaddr = 32'h40;
        step();
        @(negedge CLK);
        chk("tie2_ramaddr", ramaddr, 32'h200);
        chk("tie2_ren", ramREN, 1);
        step();
        RST = 1;
        @(negedge CLK);
        chk("rst_mid_iwait", iwait, 1);
        chk("rst_mid_dwait", dwait, 1);
        step();
        RST = 0; iREN = 0; dREN = 0;
        @(negedge CLK);
        chk("rst_after_ren", ramREN, 0);
        chk("rst_after_wen", ramWEN, 0);
        chk("rst_after_fault", fault, 0);
        chk("rst_after_iwait", iwait, 0);
        step();

        chk("strobes_never_both", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
